// File: rtl/io_sd_multi.sv
// Multi-slot SD image controller: bus register file, shared 512-byte sector
// buffer, per-slot mount tracking and a request/transfer FSM with timeout.
module io_sd_multi #(
    parameter int          SLOTS          = 2,
    parameter logic [6:0]  SEL_BASE       = 7'h10,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd5_000_000
) (
    input  logic                  system_clock,
    input  logic                  hardware_reset,
    input  logic [27:0]           hardware_addr,
    input  logic [31:0]           hardware_data_in,
    output logic [31:0]           hardware_data_out,
    input  logic [3:0]            hardware_data_sel,
    input  logic                  hardware_write,
    input  logic                  hardware_ready,
    output logic                  hardware_ack,
    output logic [31:0]           sd_lba,
    output logic [SLOTS-1:0]      sd_rd,
    output logic [SLOTS-1:0]      sd_wr,
    input  logic [SLOTS-1:0]      sd_ack,
    input  logic [7:0]            sd_buff_addr,
    input  logic [15:0]           sd_buff_dout,
    output logic [15:0]           sd_buff_din,
    input  logic                  sd_buff_wr,
    input  logic [SLOTS-1:0]      img_mounted,
    input  logic [SLOTS-1:0]      img_readonly,
    input  logic [64*SLOTS-1:0]   img_size,
    output logic [1:0]            dbg_state_o
);

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_REQ = 2'd1, ST_XFER = 2'd2} state_t;

    state_t      state_q, state_d;
    logic [31:0] lba_q, lba_d;
    logic [1:0]  slot_q, slot_d;
    logic        dir_q, dir_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [6:0]  ptr_q, ptr_d;
    logic        ack_q, ack_d;
    logic [31:0] rdata_q, rdata_d;
    logic [23:0] tmo_q, tmo_d;
    logic [SLOTS-1:0] mounted_q, mounted_d, changed_q, changed_d, rdonly_q, rdonly_d, mnt_prev_q;
    logic [63:0] size_q [SLOTS];
    logic [63:0] size_d [SLOTS];
    logic [31:0] ram [128];
    logic [31:0] ram_rd_q;
    logic [15:0] sd_din_q;

    logic [6:0]  reg_off;
    logic        hit, acc_start, busy, wr_ctrl, wr_mount, ram_we, sd_we;
    logic        cmd_req, cmd_go, timeout;
    logic        mounted_sel, rdonly_sel, ack_sel, new_mounted, new_rdonly;
    logic [63:0] size_sel;
    logic [31:0] rd_word;
    logic        unused_ok;

    assign unused_ok = &{1'b0, hardware_addr[27:7]};

    assign reg_off   = hardware_addr[6:0] - SEL_BASE;
    assign hit       = reg_off < 7'd6;
    // One register effect per ready pulse: only the first cycle of an access acts.
    assign acc_start = hardware_ready & hit & ~ack_q;
    assign wr_ctrl   = acc_start & hardware_write & (reg_off == 7'd1);
    assign wr_mount  = acc_start & hardware_write & (reg_off == 7'd3);
    assign ram_we    = acc_start & hardware_write & (reg_off == 7'd2) & ~busy;
    assign sd_we     = sd_buff_wr & ack_sel;

    always_comb begin
        mounted_sel = 1'b0;
        rdonly_sel  = 1'b0;
        ack_sel     = 1'b0;
        size_sel    = 64'd0;
        new_mounted = 1'b0;
        new_rdonly  = 1'b0;
        for (int n = 0; n < SLOTS; n++) begin
            if (slot_q == 2'(n)) begin
                mounted_sel = mounted_q[n];
                rdonly_sel  = rdonly_q[n];
                ack_sel     = sd_ack[n];
                size_sel    = size_q[n];
            end
            if (hardware_data_in[9:8] == 2'(n)) begin
                new_mounted = mounted_q[n];
                new_rdonly  = rdonly_q[n];
            end
        end
    end

    // A slot index beyond SLOTS never matches above, so it reads as unmounted.
    assign cmd_req = wr_ctrl & ~busy & (hardware_data_in[0] | hardware_data_in[1]);
    assign cmd_go  = cmd_req & done_q & new_mounted & ~(hardware_data_in[1] & new_rdonly);
    assign timeout = (state_q == ST_REQ) & ~ack_sel & (tmo_q == TIMEOUT_CYCLES - 24'd1);

    always_ff @(posedge system_clock or posedge hardware_reset) begin
        if (hardware_reset) state_q <= ST_IDLE;
        else                state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (cmd_go) state_d = ST_REQ;
            ST_REQ:  begin
                if (ack_sel)      state_d = ST_XFER;
                else if (timeout) state_d = ST_IDLE;
            end
            ST_XFER: if (!ack_sel) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy  = (state_q != ST_IDLE);
        sd_rd = '0;
        sd_wr = '0;
        for (int n = 0; n < SLOTS; n++) begin
            if (state_q == ST_REQ && slot_q == 2'(n)) begin
                sd_rd[n] = ~dir_q;
                sd_wr[n] = dir_q;
            end
        end
    end

    always_comb begin
        case (reg_off)
            7'd0:    rd_word = lba_q;
            7'd1:    rd_word = {20'd0, err_q, busy, done_q, rdonly_sel, 6'd0, slot_q};
            7'd2:    rd_word = busy ? 32'd0 : ram_rd_q;
            7'd3:    rd_word = {8'd0, 8'(changed_q), 8'(rdonly_q), 8'(mounted_q)};
            7'd4:    rd_word = size_sel[31:0];
            7'd5:    rd_word = size_sel[63:32];
            default: rd_word = 32'd0;
        endcase
    end

    always_comb begin
        lba_d   = lba_q;
        slot_d  = slot_q;
        dir_d   = dir_q;
        done_d  = done_q;
        err_d   = err_q;
        ptr_d   = ptr_q;
        ack_d   = hardware_ready & hit;
        tmo_d   = (state_q == ST_REQ) ? tmo_q + 24'd1 : 24'd0;
        rdata_d = ack_d ? rdata_q : 32'd0;
        if (acc_start && !hardware_write) rdata_d = rd_word;
        if (acc_start && hardware_write && reg_off == 7'd0) lba_d = hardware_data_in;
        if (acc_start && reg_off == 7'd2 && !busy) ptr_d = ptr_q + 7'd1;
        if (wr_ctrl && !busy) begin
            slot_d = hardware_data_in[9:8];
            if (hardware_data_in[2]) ptr_d = 7'd0;
            if (hardware_data_in[3]) err_d = 1'b0;
            if (cmd_go) begin
                done_d = 1'b0;
                ptr_d  = 7'd0;
                dir_d  = hardware_data_in[1];
            end else if (cmd_req) begin
                err_d = 1'b1;
            end
        end
        if (timeout) begin
            err_d  = 1'b1;
            done_d = 1'b1;
        end
        if (state_q == ST_XFER && !ack_sel) done_d = 1'b1;
    end

    always_comb begin
        mounted_d = mounted_q;
        changed_d = changed_q;
        rdonly_d  = rdonly_q;
        size_d    = size_q;
        for (int n = 0; n < SLOTS; n++) begin
            if (wr_mount && hardware_data_in[16+n]) changed_d[n] = 1'b0;
            // A new mount wins over a same-cycle clear of its changed flag.
            if (img_mounted[n] && !mnt_prev_q[n]) begin
                mounted_d[n] = |img_size[64*n +: 64];
                changed_d[n] = 1'b1;
                rdonly_d[n]  = img_readonly[n];
                size_d[n]    = img_size[64*n +: 64];
            end
        end
    end

    always_ff @(posedge system_clock or posedge hardware_reset) begin
        if (hardware_reset) begin
            lba_q      <= 32'd0;
            slot_q     <= 2'd0;
            dir_q      <= 1'b0;
            done_q     <= 1'b1;
            err_q      <= 1'b0;
            ptr_q      <= 7'd0;
            ack_q      <= 1'b0;
            rdata_q    <= 32'd0;
            tmo_q      <= 24'd0;
            mounted_q  <= '0;
            changed_q  <= '0;
            rdonly_q   <= '0;
            mnt_prev_q <= '0;
            sd_din_q   <= 16'd0;
            for (int n = 0; n < SLOTS; n++) size_q[n] <= 64'd0;
        end else begin
            lba_q      <= lba_d;
            slot_q     <= slot_d;
            dir_q      <= dir_d;
            done_q     <= done_d;
            err_q      <= err_d;
            ptr_q      <= ptr_d;
            ack_q      <= ack_d;
            rdata_q    <= rdata_d;
            tmo_q      <= tmo_d;
            mounted_q  <= mounted_d;
            changed_q  <= changed_d;
            rdonly_q   <= rdonly_d;
            mnt_prev_q <= img_mounted;
            size_q     <= size_d;
            sd_din_q   <= sd_buff_addr[0] ? ram[sd_buff_addr[7:1]][31:16] : ram[sd_buff_addr[7:1]][15:0];
        end
    end

    // Bus read port follows the pointer every cycle so DATA reads see ram[ptr].
    always_ff @(posedge system_clock) begin
        if (ram_we) begin
            for (int b = 0; b < 4; b++)
                if (hardware_data_sel[b]) ram[ptr_q][8*b +: 8] <= hardware_data_in[8*b +: 8];
        end
        if (sd_we) begin
            if (sd_buff_addr[0]) ram[sd_buff_addr[7:1]][31:16] <= sd_buff_dout;
            else                 ram[sd_buff_addr[7:1]][15:0]  <= sd_buff_dout;
        end
        ram_rd_q <= ram[ptr_q];
    end

    assign hardware_ack      = ack_q;
    assign hardware_data_out = rdata_q;
    assign sd_lba            = lba_q;
    assign sd_buff_din       = sd_din_q;
    assign dbg_state_o       = state_q;

endmodule
